mem_access: RTL and testbench

//  Memory-access stage of the non-pipelined multicycle MIPS core; sits between execute and writeback.
//  In the MEM state, runs one req/ack transaction on the data-memory port for lb/lbu/lh/lhu/lw/sb/sh/sw.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access.sv | 144 ++++++++++++++
 tb/tb_mem_access.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: one-hot core states and
// memory access size codes.
package mips_pkg;

  // One-hot core state encoding (only the states this slice cares about)
  localparam logic [5:0] ST_IF  = 6'b000001;
  localparam logic [5:0] ST_ID  = 6'b000010;
  localparam logic [5:0] ST_EX  = 6'b000100;
  localparam logic [5:0] ST_MEM = 6'b010000;
  localparam logic [5:0] ST_WB  = 6'b100000;

  // Data memory access size
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } msize_t;

  // Access attributes captured at MEM entry, used to extract the load lane
  typedef struct packed {
    msize_t     size;
    logic       sgn;
    logic [1:0] addr_lo;
  } mem_lat_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling for the data memory port: byte enables and
// replicated store data, load lane extraction with sign/zero extension, and
// the alignment check.
module mem_lane_align
  import mips_pkg::*;
(
  input  msize_t      size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane select, enables and store replication
  always_comb begin
    be       = 4'b0000;
    wdata    = sd;
    rext     = rdata;
    misalign = 1'b0;
    rbyte    = rdata[8*addr_lo +: 8];
    rhalf    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{sd[7:0]}};
        rext  = {{24{sgn & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{sd[15:0]}};
        rext     = {{16{sgn & rhalf[15]}}, rhalf};
        misalign = addr_lo[0];
      end
      SZ_W: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage of the multicycle MIPS core. On entry to MEM it runs a
// single req/ack transaction on the data memory port, aligns and extends load
// data, and holds the result on Readdata through writeback.
module mem_access
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  state,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] AluResult,
  input  logic [31:0] StoreData,
  output logic [31:0] Readdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} fsm_t;

  fsm_t          fsm;
  logic          mem_q;
  logic [CW-1:0] cnt;
  mem_lat_t      lat;

  logic          is_mem, entry, use_live;
  msize_t        al_size;
  logic          al_sgn;
  logic [1:0]    al_lo;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_rext;
  logic          al_mis;
  logic          bad;

  assign is_mem = (state == ST_MEM);
  assign entry  = is_mem & ~mem_q;

  // While idle the aligner sees the live instruction so the entry decision and
  // the registered port fields come from it; afterwards it sees the captured
  // attributes so the ack-cycle lane extraction does not depend on the core
  // keeping its operands steady.
  assign use_live = (fsm == S_IDLE);
  assign al_size  = use_live ? msize_t'(MemSize) : lat.size;
  assign al_sgn   = use_live ? MemSigned : lat.sgn;
  assign al_lo    = use_live ? AluResult[1:0] : lat.addr_lo;

  mem_lane_align u_align (
    .size     (al_size),
    .sgn      (al_sgn),
    .addr_lo  (al_lo),
    .sd       (StoreData),
    .rdata    (dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .rext     (al_rext),
    .misalign (al_mis)
  );

  assign bad = (MemRead & MemWrite) | (MemSize == SZ_X) | al_mis;

  // MEM-stage control FSM with registered port and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      mem_q      <= 1'b0;
      cnt        <= '0;
      lat        <= '0;
      Readdata   <= '0;
      mem_done   <= 1'b0;
      mem_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      mem_q    <= is_mem;
      mem_done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (entry) begin
            if (!MemRead && !MemWrite) begin
              mem_done <= 1'b1;
              fsm      <= S_DONE;
            end else if (bad) begin
              mem_err  <= 1'b1;
              mem_done <= 1'b1;
              fsm      <= S_DONE;
            end else begin
              dmem_req    <= 1'b1;
              dmem_we     <= MemWrite;
              dmem_addr   <= {AluResult[31:2], 2'b00};
              dmem_be     <= al_be;
              dmem_wdata  <= al_wdata;
              lat.size    <= msize_t'(MemSize);
              lat.sgn     <= MemSigned;
              lat.addr_lo <= AluResult[1:0];
              cnt         <= '0;
              fsm         <= S_ACC;
            end
          end
        end
        S_ACC: begin
          // Core moving on wins over a same-cycle ack: the instruction is gone
          if (!is_mem) begin
            dmem_req <= 1'b0;
            fsm      <= S_IDLE;
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) Readdata <= al_rext;
            mem_done <= 1'b1;
            fsm      <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
            mem_done <= 1'b1;
            fsm      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!is_mem) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads/stores with hand-computed lane results,
// error paths, timeout, abort and asynchronous reset.
module tb_mem_access;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  state;
  logic        MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] AluResult, StoreData;
  logic [31:0] Readdata;
  logic        mem_done, mem_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemSize    (MemSize),
    .MemSigned  (MemSigned),
    .AluResult  (AluResult),
    .StoreData  (StoreData),
    .Readdata   (Readdata),
    .mem_done   (mem_done),
    .mem_err    (mem_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and enter MEM; returns just after the entry edge
  task automatic enter(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr, input logic [31:0] sd);
    MemRead   = rd;
    MemWrite  = wr;
    MemSize   = sz;
    MemSigned = sg;
    AluResult = addr;
    StoreData = sd;
    state     = ST_MEM;
    tick();
  endtask

  // Move through WB back to fetch
  task automatic leave();
    state = ST_WB;
    tick();
    state = ST_IF;
    tick();
  endtask

  // Load with ack in the first request cycle
  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_rd);
    enter(1'b1, 1'b0, sz, sg, addr, 32'h0);
    chk({tag, ".req"},  32'(dmem_req), 32'd1);
    chk({tag, ".we"},   32'(dmem_we),  32'd0);
    chk({tag, ".be"},   32'(dmem_be),  32'(exp_be));
    chk({tag, ".addr"}, dmem_addr,     {addr[31:2], 2'b00});
    chk({tag, ".done_early"}, 32'(mem_done), 32'd0);
    dmem_rdata = rdata;
    dmem_ack   = 1'b1;
    tick();
    dmem_ack   = 1'b0;
    chk({tag, ".done"}, 32'(mem_done), 32'd1);
    chk({tag, ".req_off"}, 32'(dmem_req), 32'd0);
    chk({tag, ".rd"},   Readdata, exp_rd);
    tick();
    chk({tag, ".done_pulse"}, 32'(mem_done), 32'd0);
    chk({tag, ".rd_hold"}, Readdata, exp_rd);
    leave();
  endtask

  int n;

  initial begin
    rst_n = 1'b0; state = ST_IF;
    MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
    AluResult = 0; StoreData = 0; dmem_rdata = 0; dmem_ack = 0;
    tick(); tick();
    chk("rst.rd",   Readdata,          32'h0);
    chk("rst.done", 32'(mem_done),     32'd0);
    chk("rst.err",  32'(mem_err),      32'd0);
    chk("rst.req",  32'(dmem_req),     32'd0);
    chk("rst.be",   32'(dmem_be),      32'd0);
    rst_n = 1'b1;
    tick();

    // Loads: word, signed/unsigned byte at lane 3, signed half at upper lanes
    do_load("lw",  SZ_W, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_load("lb",  SZ_B, 1'b1, 32'h103, 32'h80112233, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", SZ_B, 1'b0, 32'h103, 32'h80112233, 4'b1000, 32'h00000080);
    do_load("lh",  SZ_H, 1'b1, 32'h502, 32'h80010000, 4'b1100, 32'hFFFF8001);
    do_load("lhu", SZ_H, 1'b0, 32'h500, 32'h1234F00D, 4'b0011, 32'h0000F00D);

    // Store halfword: Readdata untouched
    enter(1'b0, 1'b1, SZ_H, 1'b0, 32'h202, 32'h0000ABCD);
    chk("sh.req",   32'(dmem_req), 32'd1);
    chk("sh.we",    32'(dmem_we),  32'd1);
    chk("sh.be",    32'(dmem_be),  32'hC);
    chk("sh.wdata", dmem_wdata,    32'hABCDABCD);
    chk("sh.addr",  dmem_addr,     32'h200);
    dmem_rdata = 32'h55555555;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sh.done", 32'(mem_done), 32'd1);
    chk("sh.rd",   Readdata,      32'h0000F00D);
    leave();

    // Store byte at lane 1
    enter(1'b0, 1'b1, SZ_B, 1'b0, 32'h305, 32'h123456A5);
    chk("sb.be",    32'(dmem_be), 32'h2);
    chk("sb.wdata", dmem_wdata,   32'hA5A5A5A5);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    leave();

    // No-access instruction
    enter(1'b0, 1'b0, SZ_W, 1'b0, 32'h101, 32'h0);
    chk("nop.req",  32'(dmem_req), 32'd0);
    chk("nop.done", 32'(mem_done), 32'd1);
    chk("nop.err",  32'(mem_err),  32'd0);
    tick();
    chk("nop.pulse", 32'(mem_done), 32'd0);
    leave();

    // Misaligned word
    enter(1'b1, 1'b0, SZ_W, 1'b0, 32'h101, 32'h0);
    chk("mis.req",  32'(dmem_req), 32'd0);
    chk("mis.done", 32'(mem_done), 32'd1);
    chk("mis.err",  32'(mem_err),  32'd1);
    tick();
    chk("mis.pulse", 32'(mem_done), 32'd0);
    chk("mis.noreq", 32'(dmem_req), 32'd0);
    leave();
    chk("mis.sticky", 32'(mem_err), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Read and write both set
    enter(1'b1, 1'b1, SZ_W, 1'b0, 32'h100, 32'h0);
    chk("rw.req", 32'(dmem_req), 32'd0);
    chk("rw.err", 32'(mem_err),  32'd1);
    leave();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Illegal size
    enter(1'b1, 1'b0, SZ_X, 1'b0, 32'h100, 32'h0);
    chk("sz.req",  32'(dmem_req), 32'd0);
    chk("sz.err",  32'(mem_err),  32'd1);
    chk("sz.done", 32'(mem_done), 32'd1);
    leave();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Timeout: give Readdata a known value first
    do_load("lw2", SZ_W, 1'b0, 32'h104, 32'h12345678, 4'b1111, 32'h12345678);
    enter(1'b1, 1'b0, SZ_W, 1'b0, 32'h300, 32'h0);
    n = 0;
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to.cycles", 32'(n),         32'd16);
    chk("to.req",    32'(dmem_req),  32'd0);
    chk("to.err",    32'(mem_err),   32'd1);
    chk("to.done",   32'(mem_done),  32'd1);
    chk("to.rd",     Readdata,       32'h12345678);
    dmem_rdata = 32'hFFFFFFFF;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("late.rd",   Readdata,      32'h12345678);
    chk("late.done", 32'(mem_done), 32'd0);
    chk("late.req",  32'(dmem_req), 32'd0);
    leave();

    // Asynchronous reset in the middle of an access
    enter(1'b1, 1'b0, SZ_W, 1'b0, 32'h400, 32'h0);
    chk("ar.req_pre", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.req",  32'(dmem_req), 32'd0);
    chk("ar.done", 32'(mem_done), 32'd0);
    chk("ar.rd",   Readdata,      32'h0);
    chk("ar.err",  32'(mem_err),  32'd0);
    state = ST_IF;
    tick();
    rst_n = 1'b1;
    tick();

    // Core leaves MEM during the access
    enter(1'b1, 1'b0, SZ_W, 1'b0, 32'h600, 32'h0);
    chk("ab.req_pre", 32'(dmem_req), 32'd1);
    state = ST_WB;
    tick();
    chk("ab.req",  32'(dmem_req), 32'd0);
    chk("ab.done", 32'(mem_done), 32'd0);
    state = ST_IF;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("ab.done2", 32'(mem_done), 32'd0);
    chk("ab.err",   32'(mem_err),  32'd0);
    chk("ab.rd",    Readdata,      32'h0);
    tick();

    // Normal access works after an abort
    do_load("lw3", SZ_W, 1'b0, 32'h700, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
